// File: rtl/sm_pkg.sv
// Shared constants and types for the sign-magnitude serial arithmetic blocks.
package sm_pkg;

    localparam int unsigned SM_WIDTH    = 16;
    localparam int unsigned SM_SIGN_BIT = SM_WIDTH - 1;
    localparam int unsigned SM_MAG_W    = SM_WIDTH - 1;
    localparam int unsigned SM_CNT_W    = 4;

    // The counter walks the magnitude bits, then spends one extra count on write-back.
    localparam logic [SM_CNT_W-1:0] SM_CNT_FIN = SM_CNT_W'(SM_MAG_W);

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } sm_state_e;

endpackage

// File: rtl/sm_serial_sub_if.sv
// Operand/result handshake bundle for sm_serial_sub; the op signal exists only
// when SM_SUB_ADD_MODE_EN is defined.
interface sm_serial_sub_if;
    import sm_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [SM_WIDTH-1:0] a;
    logic [SM_WIDTH-1:0] b;
`ifdef SM_SUB_ADD_MODE_EN
    logic                op;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [SM_WIDTH-1:0] result;
    logic                overflow;
    logic                zero;

`ifdef SM_SUB_ADD_MODE_EN
    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, overflow, zero
    );
    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, overflow, zero
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, overflow, zero
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, overflow, zero
    );
`endif

endinterface

// File: rtl/sm_mag_compare.sv
// Combinational unsigned magnitude comparator used to order operands at capture.
module sm_mag_compare #(
    parameter int unsigned Width = 15
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic             gt_o,
    output logic             eq_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);

endmodule

// File: rtl/sm_serial_sub.sv
// Bit-serial sign-magnitude subtractor, one magnitude bit per cycle, LSB first.
// Defining SM_SUB_ADD_MODE_EN adds the op input (0 = add, 1 = subtract).
module sm_serial_sub
    import sm_pkg::*;
(
    input logic             clk,
    input logic             reset,
    sm_serial_sub_if.slave  sm_if
);

    sm_state_e             state_q, state_d;
    logic [SM_MAG_W-1:0]   x_q, x_d, y_q, y_d, mag_q, mag_d;
    logic [SM_CNT_W-1:0]   cnt_q, cnt_d;
    logic                  carry_q, carry_d;
    logic                  add_q, add_d;
    logic                  sign_q, sign_d;
    logic [SM_WIDTH-1:0]   result_q, result_d;
    logic                  overflow_q, overflow_d;
    logic                  zero_q, zero_d;

    logic a_gt, a_eq;
    logic a_sign, eff_b_sign;
    logic xb, yb, bit_res, bit_carry;

    sm_mag_compare #(
        .Width (SM_MAG_W)
    ) u_cmp (
        .a_i  (sm_if.a[SM_MAG_W-1:0]),
        .b_i  (sm_if.b[SM_MAG_W-1:0]),
        .gt_o (a_gt),
        .eq_o (a_eq)
    );

    assign a_sign = sm_if.a[SM_SIGN_BIT];
`ifdef SM_SUB_ADD_MODE_EN
    assign eff_b_sign = (sm_if.op == OP_SUB) ? ~sm_if.b[SM_SIGN_BIT] : sm_if.b[SM_SIGN_BIT];
`else
    assign eff_b_sign = ~sm_if.b[SM_SIGN_BIT];
`endif

    // One full adder / full subtractor cell; carry_q holds carry or borrow per add_q.
    assign xb        = x_q[0];
    assign yb        = y_q[0];
    assign bit_res   = xb ^ yb ^ carry_q;
    assign bit_carry = add_q ? ((xb & yb) | (carry_q & (xb ^ yb)))
                             : ((~xb & yb) | (~(xb ^ yb) & carry_q));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        add_d      = add_q;
        sign_d     = sign_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        unique case (state_q)
            IDLE: begin
                if (sm_if.in_valid) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    mag_d   = '0;
                    if (a_sign == eff_b_sign) begin
                        add_d  = 1'b1;
                        x_d    = sm_if.a[SM_MAG_W-1:0];
                        y_d    = sm_if.b[SM_MAG_W-1:0];
                        sign_d = a_sign;
                    end else if (a_gt || a_eq) begin
                        add_d  = 1'b0;
                        x_d    = sm_if.a[SM_MAG_W-1:0];
                        y_d    = sm_if.b[SM_MAG_W-1:0];
                        sign_d = a_sign;
                    end else begin
                        add_d  = 1'b0;
                        x_d    = sm_if.b[SM_MAG_W-1:0];
                        y_d    = sm_if.a[SM_MAG_W-1:0];
                        sign_d = eff_b_sign;
                    end
                end
            end
            CALC: begin
                if (cnt_q == SM_CNT_FIN) begin
                    state_d    = DONE;
                    cnt_d      = '0;
                    overflow_d = add_q & carry_q;
                    zero_d     = (mag_q == '0);
                    // Zero magnitude always reports +0.
                    result_d   = {sign_q & (mag_q != '0), mag_q};
                end else begin
                    x_d     = x_q >> 1;
                    y_d     = y_q >> 1;
                    mag_d   = {bit_res, mag_q[SM_MAG_W-1:1]};
                    carry_d = bit_carry;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (sm_if.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            add_q      <= 1'b0;
            sign_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            add_q      <= add_d;
            sign_q     <= sign_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign sm_if.in_ready  = (state_q == IDLE);
    assign sm_if.out_valid = (state_q == DONE);
    assign sm_if.result    = result_q;
    assign sm_if.overflow  = overflow_q;
    assign sm_if.zero      = zero_q;

endmodule

// File: tb/tb_sm_serial_sub.sv
// Scoreboard bench for sm_serial_sub: integer reference model, randomized operands,
// decoupled driver and monitor. Exercises op when SM_SUB_ADD_MODE_EN is defined.
module tb_sm_serial_sub;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        logic        zero;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t head;
    logic prev_v;
    logic post_hs;

    sm_serial_sub_if bus ();

    sm_serial_sub dut (
        .clk   (clk),
        .reset (reset),
        .sm_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Signed-integer arithmetic on decoded operands, then re-encode.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic op);
        exp_t e;
        int av, bv, s, m;
        av = int'(a[14:0]);
        if (a[15]) av = -av;
        bv = int'(b[14:0]);
        if (b[15]) bv = -bv;
        s = op ? (av - bv) : (av + bv);
        m = (s < 0) ? -s : s;
        e.ovf  = (m > 32767);
        m      = m % 32768;
        e.zero = (m == 0);
        e.res  = {(s < 0) && (m != 0), 15'(m)};
        e.acc  = 0;
        return e;
    endfunction

    // Monitor: pops on output handshake, checks latency, stability and in_ready.
    always @(negedge clk) begin
        if (reset) begin
            prev_v  = 1'b0;
            post_hs = 1'b0;
        end else begin
            if (post_hs) begin
                chk("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
                post_hs = 1'b0;
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got 1, expected 0 (cycle %0d)", cyc);
                end else begin
                    head = exp_q[0];
                    if (!prev_v) chk("latency", 32'(cyc - head.acc), 32'd16);
                    chk("result", 32'(bus.result), 32'(head.res));
                    chk("overflow", 32'(bus.overflow), 32'(head.ovf));
                    chk("zero", 32'(bus.zero), 32'(head.zero));
                    chk("in_ready_in_done", 32'(bus.in_ready), 32'd0);
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        post_hs = 1'b1;
                    end
                end
            end
            prev_v = bus.out_valid;
        end
    end

    task automatic set_op(input logic op);
`ifdef SM_SUB_ADD_MODE_EN
        bus.op = op;
`endif
    endtask

    // Drive operands, wait for accept, push expectation. Inputs change at posedge+1.
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic op,
                          input bit noise, output bit ok);
        int   t;
        logic eff_op;
        exp_t e;
`ifdef SM_SUB_ADD_MODE_EN
        eff_op = op;
`else
        eff_op = 1'b1;
`endif
        bus.a = a;
        bus.b = b;
        set_op(op);
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        ok = bus.in_ready;
        if (!ok) begin
            chk("accept_timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        e     = model(a, b, eff_op);
        e.acc = cyc;
        exp_q.push_back(e);
        if (noise) begin
            // Garbage offered during CALC must not be sampled.
            bus.a = 16'($urandom);
            bus.b = 16'($urandom);
            set_op(1'($urandom));
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic drain(input int hold);
        int t;
        t = 0;
        while (!bus.out_valid && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        bus.in_valid = 1'b0;
        if (!bus.out_valid) begin
            chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic txn(input logic [15:0] a, input logic [15:0] b, input logic op,
                       input int hold, input bit noise);
        bit ok;
        accept(a, b, op, noise, ok);
        if (ok) drain(hold);
    endtask

    function automatic logic [15:0] pick();
        logic [15:0] sp[6];
        sp = '{16'h0000, 16'h8000, 16'h7FFF, 16'hFFFF, 16'h0001, 16'h8001};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 5)];
        return 16'($urandom);
    endfunction

    initial begin
        bit ok;
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        set_op(1'b1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_result", 32'(bus.result), 32'h0000);
        chk("reset_overflow", 32'(bus.overflow), 32'd0);
        chk("reset_zero", 32'(bus.zero), 32'd0);
        @(posedge clk); #1;

        txn(16'h0005, 16'h0003, 1'b1, 0, 1'b0);
        txn(16'h0003, 16'h0005, 1'b1, 1, 1'b0);
        txn(16'h8004, 16'h8004, 1'b1, 0, 1'b0);
        txn(16'h7FFF, 16'h8001, 1'b1, 2, 1'b0);
        txn(16'h8000, 16'h0000, 1'b1, 0, 1'b0);
        txn(16'h1234, 16'h0234, 1'b1, 5, 1'b1);
        txn(16'h0003, 16'h0005, 1'b1, 0, 1'b0);

        // Abort mid-CALC after bit 7; the previous result (0x8002) must be wiped.
        accept(16'h1234, 16'h0001, 1'b1, 1'b0, ok);
        repeat (8) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset_result", 32'(bus.result), 32'h0000);
        chk("midreset_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        txn(16'h0010, 16'h0001, 1'b1, 0, 1'b0);

`ifdef SM_SUB_ADD_MODE_EN
        txn(16'h8003, 16'h0005, 1'b0, 0, 1'b0);
        txn(16'h8003, 16'h0005, 1'b1, 0, 1'b0);
`endif

        for (int i = 0; i < 40; i++) begin
            txn(pick(), pick(), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
